// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
//   state_t  : FSM states (IDLE, RUN, DONE)
//   MODE_ADD : mode input value selecting a + b + cin
//   MODE_SUB : mode input value selecting a - b - cin
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational one-bit full adder used by the serial datapath.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   c         : carry out (majority of the three inputs)
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first, WIDTH cycles.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : operation request, honoured in IDLE or DONE only
//   mode       : 0 = a + b + cin, 1 = a - b - cin
//   cin        : carry-in (add) / borrow-in (subtract)
//   a, b       : operands captured on an accepted start
//   busy       : high while the operation is running
//   done       : one-cycle pulse when result/cout/overflow are valid
//   result     : sum or difference, modulo 2^WIDTH
//   cout       : final carry (subtract: 1 = no borrow)
//   overflow   : two's-complement signed overflow
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_addsub: WIDTH must be 2 or more");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_overflow;

    logic               w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_last;

    // A new operation may begin from IDLE or directly from DONE, which
    // gives back-to-back operation without an idle bubble.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    serial_fa_cell u_fa (
        .a   (r_opa[0]),
        .b   (r_opb[0]),
        .cin (r_carry),
        .s   (w_s),
        .c   (w_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in is inverted
            // into the initial carry.
            r_opa   <= a;
            r_opb   <= (mode == MODE_SUB) ? ~b : b;
            r_carry <= (mode == MODE_SUB) ? ~cin : cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_result <= {w_s, r_result[WIDTH-1:1]};
            r_carry  <= w_c;
            r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // Signed overflow: carry into the MSB differs from carry out.
                r_cout     <= w_c;
                r_overflow <= w_c ^ r_carry;
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH = 8): directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_serial_addsub;
    import serial_arith_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    logic [W-1:0] exp_r;
    logic         exp_co;
    logic         exp_ov;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic om, input logic oc);
        int u;
        int s;
        if (om == MODE_ADD) begin
            u = int'(oa) + int'(ob) + int'(oc);
            s = to_signed(oa) + to_signed(ob) + int'(oc);
            exp_co = (u >= (1 << W));
        end else begin
            u = int'(oa) - int'(ob) - int'(oc);
            s = to_signed(oa) - to_signed(ob) - int'(oc);
            exp_co = (u >= 0);
        end
        exp_r  = W'(u & ((1 << W) - 1));
        exp_ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    endtask

    // Called at a negedge; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                            input logic om, input logic oc);
        a = oa; b = ob; mode = om; cin = oc; start = 1'b1;
        model(oa, ob, om, oc);
        @(posedge clk);
    endtask

    // Waits (bounded) for done, optionally disturbing inputs during RUN.
    task automatic finish_op(input string tag, input bit noise);
        int edges = 0;
        int busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (noise) begin
                a = W'($urandom); b = W'($urandom);
                mode = 1'($urandom); cin = 1'($urandom);
                start = (edges < W - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        last_done_cyc = cyc;
        $display("op %s: result=%0h cout=%0d ovf=%0d latency=%0d (model %0h/%0d/%0d)",
                 tag, result, cout, overflow, edges, exp_r, exp_co, exp_ov);
        check({tag, ".latency"}, edges, W);
        check({tag, ".busy_cycles"}, busy_cnt, W);
        check({tag, ".busy_at_done"}, busy, 1'b0);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".cout"}, cout, exp_co);
        check({tag, ".overflow"}, overflow, exp_ov);
    endtask

    // One cycle after DONE with start low: back to IDLE, outputs held.
    task automatic check_hold(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".idle_busy"}, busy, 1'b0);
        check({tag, ".hold_result"}, result, exp_r);
        check({tag, ".hold_cout"}, cout, exp_co);
        check({tag, ".hold_ovf"}, overflow, exp_ov);
    endtask

    initial begin
        int first_done;
        int done_seen;
        bit chain;

        reset = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.result", result, '0);
        check("rst.cout", cout, 1'b0);
        check("rst.ovf", overflow, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        start_op(8'h5A, 8'h3C, MODE_ADD, 1'b0); finish_op("add5A3C", 1'b0); check_hold("add5A3C");
        start_op(8'hFF, 8'h01, MODE_ADD, 1'b0); finish_op("addFF01", 1'b0); check_hold("addFF01");
        start_op(8'h10, 8'h20, MODE_SUB, 1'b0); finish_op("sub1020", 1'b0); check_hold("sub1020");
        start_op(8'h80, 8'h01, MODE_SUB, 1'b0); finish_op("sub8001", 1'b0); check_hold("sub8001");

        // Asynchronous reset in the middle of RUN.
        start_op(8'h33, 8'h44, MODE_ADD, 1'b0);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.busy", busy, 1'b0);
        check("midrst.done", done, 1'b0);
        check("midrst.result", result, '0);
        check("midrst.cout", cout, 1'b0);
        check("midrst.ovf", overflow, 1'b0);
        @(negedge clk); reset = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("midrst.no_activity", done_seen, 0);
        start_op(8'h21, 8'h12, MODE_ADD, 1'b1); finish_op("postrst", 1'b0); check_hold("postrst");

        // Inputs disturbed during RUN must not matter.
        start_op(8'h03, 8'h04, MODE_ADD, 1'b0); finish_op("noise0304", 1'b1); check_hold("noise0304");

        // Back-to-back: second start accepted on the DONE edge.
        start_op(8'h05, 8'h06, MODE_ADD, 1'b0); finish_op("b2b_first", 1'b0);
        first_done = last_done_cyc;
        start_op(8'h01, 8'h01, MODE_ADD, 1'b0); finish_op("b2b_second", 1'b0);
        check("b2b.gap", last_done_cyc - first_done, W + 1);
        check_hold("b2b_second");

        for (int i = 0; i < 40; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            finish_op($sformatf("rnd%0d", i), 1'b1);
            chain = ($urandom_range(0, 3) == 0);
            if (!chain) check_hold($sformatf("rnd%0d", i));
        end
        check_hold("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
